output_sequencer: RTL and testbench
===================================

Name: output_sequencer

Overview:
- Plays back the active half of the double-buffered pattern RAM onto the 16-bit output port.
- The input loader fills the inactive half and its variable entry, then pulses load_complete.
- This block owns active_buffer: it sequences reads from the RAM read port and swaps halves only on a frame boundary, so frames are never torn.
- It applies the per-buffer clock divisor and frame length stored in the variable RAM.

Parameters:
- DATA_WIDTH, 16, pattern word width.
- HALF_AW, 12, address width of one buffer half; the full RAM address is HALF_AW+1 bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- load_complete  in  1  one-cycle pulse from the loader: the inactive half holds a new pattern.
- active_buffer  out  1  half currently played; fed back to the loader.
- raddr  out  13  dual-port RAM read address, registered.
- rdata  in  16  RAM read data; registered RAM, valid one cycle after raddr is sampled.
- var_raddr  out  4  variable RAM read address = {3'b000, active_buffer}.
- var_rdata  in  32  variable RAM data, asynchronous read: [31:16] divisor D, [15:0] last index L.
- pattern_out  out  16  output pattern word, registered.
- frame_start  out  1  one-cycle pulse on the edge that loads word 0 of a frame.
- swap_done  out  1  one-cycle pulse on the edge that toggles active_buffer.
- running  out  1  high in states PRIME and RUN.

Behaviour:
- Reset values:
  - active_buffer=0, raddr=0, pattern_out=0.
  - frame_start=0, swap_done=0, running=0.
  - swap_pending=0, state=IDLE.
- Address rules:
  - base = active_buffer ? 4096 : 0.
  - raddr = base + idx, where idx is 12 bits.
  - Effective last index LE = min(L, 4095); a frame is LE+1 words.
- Word period:
  - P = max(D,1)+1 cycles; minimum 2 cycles, which the registered RAM read requires.
  - D=0 is treated as D=1.
- States:
  - IDLE: pattern_out=0.
    - load_complete toggles active_buffer immediately and pulses swap_done; swap_pending stays 0.
    - enable=1 goes to SETUP.
  - SETUP (1 cycle): raddr<=base, idx<=0, then PRIME.
  - PRIME (1 cycle): the RAM samples base; then RUN.
  - RUN, on each load edge:
    - pattern_out<=rdata.
    - hold counter <= P-1.
    - raddr <= address of the next word.
    - Counter decrements on other cycles; the next load occurs when the counter reaches 0.
  - Word 0 load edge:
    - Latch D and LE from var_rdata.
    - The hold counter uses the newly read D.
    - Assert frame_start.
  - Last-word load (idx==LE):
    - If swap_pending: toggle active_buffer, clear swap_pending, pulse swap_done, raddr<=new base.
    - Otherwise raddr<=base (wrap).
    - The next load is word 0 of the next frame, with no gap cycles.
- Latency: enable sampled high in IDLE at edge k → SETUP at k+1, PRIME at k+2, word 0 on pattern_out after edge k+3.
- swap_pending:
  - Set by load_complete outside IDLE.
  - A second load_complete while already pending is absorbed; only one swap occurs.
  - If load_complete coincides with the swap edge, set wins: pending=1 after that edge.
- enable deasserted in SETUP, PRIME or RUN: next edge goes to IDLE, pattern_out<=0, running<=0. active_buffer and swap_pending are preserved.
- reset overrides everything, including mid-frame; all registers return to reset values.
- L >= 4096 is clamped to 4095; idx never crosses into the other half.

Test Plan:
- Half 0 = 0x1111,0x2222,0x3333,0x4444; var[0] = {16'd2,16'd3}; pulse enable → pattern_out shows each word for 3 cycles, word 0 3 edges after enable, frame_start every 12 cycles, wrap seamless.
- Same half with var[0] D=0 → each word held 2 cycles, identical to D=1.
- While running on half 0, load half 1 (0xAAAA,0xBBBB; var[1]={1,1}) and pulse load_complete mid-frame:
  - Half 0 finishes 0x4444.
  - swap_done fires on that edge and active_buffer=1.
  - The next frame plays AAAA,BBBB at 2 cycles each with no gap.
- Two load_complete pulses within one frame, plus one pulse coinciding with the swap edge → exactly one swap at the first boundary, then swap_pending=1 and a second swap at the next boundary.
- In IDLE, pulse load_complete → active_buffer toggles the next edge and swap_done pulses; with enable=0, pattern_out stays 0.
- Assert reset in RUN mid-word, and separately drop enable → both give pattern_out=0 next edge. Reset clears active_buffer to 0; dropping enable keeps it.

Source files
------------

// File: rtl/output_sequencer.sv
// Plays back the active half of a double-buffered pattern RAM onto pattern_out.
// Half swaps are deferred to the last-word load so frames are never torn.
module output_sequencer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned HALF_AW    = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load_complete,
    output logic                  active_buffer,
    output logic [HALF_AW:0]      raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [3:0]            var_raddr,
    input  logic [31:0]           var_rdata,
    output logic [DATA_WIDTH-1:0] pattern_out,
    output logic                  frame_start,
    output logic                  swap_done,
    output logic                  running
);

    typedef enum logic [1:0] {StIdle, StSetup, StPrime, StRun} state_e;

    localparam logic [HALF_AW-1:0] MaxIdx  = '1;
    localparam logic [15:0]        MaxIdxW = 16'((1 << HALF_AW) - 1);

    state_e                  state_q, state_d;
    logic                    ab_q, ab_d;
    logic [HALF_AW:0]        raddr_q, raddr_d;
    logic [HALF_AW-1:0]      idx_q, idx_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [15:0]             div_q, div_d;
    logic [HALF_AW-1:0]      le_q, le_d;
    logic                    pend_q, pend_d;
    logic [DATA_WIDTH-1:0]   pat_q, pat_d;
    logic                    fs_q, fs_d;
    logic                    sd_q, sd_d;

    logic [15:0]             var_div;
    logic [15:0]             var_last;
    logic [HALF_AW-1:0]      var_le;
    logic                    first_word;
    logic [15:0]             div_sel;
    logic [HALF_AW-1:0]      le_sel;
    logic [15:0]             hold;

    assign var_div  = var_rdata[31:16];
    assign var_last = var_rdata[15:0];
    assign var_le   = (var_last > MaxIdxW) ? MaxIdx : var_last[HALF_AW-1:0];

    // Word 0 uses the freshly read divisor and length; later words use the latched copy.
    assign first_word = (idx_q == '0);
    assign div_sel    = first_word ? var_div : div_q;
    assign le_sel     = first_word ? var_le : le_q;
    assign hold       = (div_sel == '0) ? 16'd1 : div_sel;

    always_comb begin
        state_d = state_q;
        ab_d    = ab_q;
        raddr_d = raddr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        le_d    = le_q;
        pend_d  = pend_q | (load_complete && (state_q != StIdle));
        pat_d   = pat_q;
        fs_d    = 1'b0;
        sd_d    = 1'b0;

        if (state_q == StIdle) begin
            pat_d = '0;
            if (load_complete) begin
                ab_d = ~ab_q;
                sd_d = 1'b1;
            end
            if (enable) state_d = StSetup;
        end else if (!enable) begin
            state_d = StIdle;
            pat_d   = '0;
        end else begin
            case (state_q)
                StSetup: begin
                    raddr_d = {ab_q, {HALF_AW{1'b0}}};
                    idx_d   = '0;
                    state_d = StPrime;
                end
                StPrime: begin
                    cnt_d   = '0;
                    state_d = StRun;
                end
                StRun: begin
                    if (cnt_q == '0) begin
                        pat_d = rdata;
                        cnt_d = hold;
                        if (first_word) begin
                            div_d = var_div;
                            le_d  = var_le;
                            fs_d  = 1'b1;
                        end
                        if (idx_q == le_sel) begin
                            idx_d = '0;
                            if (pend_q) begin
                                ab_d    = ~ab_q;
                                sd_d    = 1'b1;
                                // A request arriving on the swap edge stays queued.
                                pend_d  = load_complete;
                                raddr_d = {~ab_q, {HALF_AW{1'b0}}};
                            end else begin
                                raddr_d = {ab_q, {HALF_AW{1'b0}}};
                            end
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            raddr_d = {ab_q, idx_q + 1'b1};
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ab_q    <= 1'b0;
            raddr_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            le_q    <= '0;
            pend_q  <= 1'b0;
            pat_q   <= '0;
            fs_q    <= 1'b0;
            sd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ab_q    <= ab_d;
            raddr_q <= raddr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            le_q    <= le_d;
            pend_q  <= pend_d;
            pat_q   <= pat_d;
            fs_q    <= fs_d;
            sd_q    <= sd_d;
        end
    end

    assign active_buffer = ab_q;
    assign raddr         = raddr_q;
    assign var_raddr     = {3'b000, ab_q};
    assign pattern_out   = pat_q;
    assign frame_start   = fs_q;
    assign swap_done     = sd_q;
    assign running       = (state_q == StPrime) || (state_q == StRun);

endmodule

// File: tb/tb_output_sequencer.sv
// Directed bench for output_sequencer with a registered pattern RAM and an
// asynchronous variable RAM; outputs are sampled 1 time unit after each edge.
module tb_output_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load_complete;
    logic        active_buffer;
    logic [12:0] raddr;
    logic [15:0] rdata;
    logic [3:0]  var_raddr;
    logic [31:0] var_rdata;
    logic [15:0] pattern_out;
    logic        frame_start;
    logic        swap_done;
    logic        running;

    logic [15:0] mem  [8192];
    logic [31:0] vmem [16];

    int checks = 0;
    int errors = 0;

    output_sequencer #(.DATA_WIDTH(16), .HALF_AW(12)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .load_complete (load_complete),
        .active_buffer (active_buffer),
        .raddr         (raddr),
        .rdata         (rdata),
        .var_raddr     (var_raddr),
        .var_rdata     (var_rdata),
        .pattern_out   (pattern_out),
        .frame_start   (frame_start),
        .swap_done     (swap_done),
        .running       (running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[raddr];
    assign var_rdata = vmem[var_raddr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Rows j = 0..37 after re-enabling with D=0 on half 0: input pulse and expected outputs.
    logic [15:0] t_pat [38] = '{
        16'h1111, 16'h1111, 16'h2222, 16'h2222, 16'h3333, 16'h3333, 16'h4444, 16'h4444,
        16'h1111, 16'h1111, 16'h2222, 16'h2222, 16'h3333, 16'h3333, 16'h4444, 16'h4444,
        16'hAAAA, 16'hAAAA, 16'hBBBB, 16'hBBBB, 16'hAAAA, 16'hAAAA, 16'hBBBB, 16'hBBBB,
        16'h1111, 16'h1111, 16'h2222, 16'h2222, 16'h3333, 16'h3333, 16'h4444, 16'h4444,
        16'hAAAA, 16'hAAAA, 16'hBBBB, 16'hBBBB, 16'h1111, 16'h1111};
    logic t_lc [38] = '{
        0,0,0,0,0,0,0,0,0,0,  1,0,0,0,0,0,0,0,0,0,
        0,1,0,0,0,1,0,1,0,0,  1,0,0,0,0,0,0,0};
    logic t_fs [38] = '{
        1,0,0,0,0,0,0,0,1,0,  0,0,0,0,0,0,1,0,0,0,
        1,0,0,0,1,0,0,0,0,0,  0,0,1,0,0,0,1,0};
    logic t_sd [38] = '{
        0,0,0,0,0,0,0,0,0,0,  0,0,0,0,1,0,0,0,0,0,
        0,0,1,0,0,0,0,0,0,0,  1,0,0,0,1,0,0,0};
    logic t_ab [38] = '{
        0,0,0,0,0,0,0,0,0,0,  0,0,0,0,1,1,1,1,1,1,
        1,1,0,0,0,0,0,0,0,0,  1,1,1,1,0,0,0,0};

    logic [15:0] words1 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) vmem[i] = '0;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        mem[4096] = 16'hAAAA; mem[4097] = 16'hBBBB;
        vmem[0] = {16'd2, 16'd3};
        vmem[1] = {16'd1, 16'd1};

        reset = 1'b1; enable = 1'b0; load_complete = 1'b0;
        step();
        step();
        chk("rst_pattern", 32'(pattern_out), 32'h0);
        chk("rst_active", 32'(active_buffer), 32'h0);
        chk("rst_raddr", 32'(raddr), 32'h0);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
        chk("rst_swap_done", 32'(swap_done), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        reset = 1'b0;

        // D=2: each word held 3 cycles, word 0 appears 3 edges after enable is sampled.
        enable = 1'b1;
        step();
        chk("setup_running", 32'(running), 32'h0);
        step();
        chk("prime_running", 32'(running), 32'h1);
        chk("prime_raddr", 32'(raddr), 32'h0);
        step();
        chk("run_pre_word0", 32'(pattern_out), 32'h0);
        for (int j = 0; j < 15; j++) begin
            step();
            chk($sformatf("d2_pat_%0d", j), 32'(pattern_out), 32'(words1[(j / 3) % 4]));
            chk($sformatf("d2_fs_%0d", j), 32'(frame_start), 32'((j % 12) == 0));
        end

        enable = 1'b0;
        step();
        chk("drop_pattern", 32'(pattern_out), 32'h0);
        chk("drop_running", 32'(running), 32'h0);
        chk("drop_active", 32'(active_buffer), 32'h0);

        // D=0 behaves as D=1, then mid-frame swaps including a coincident request.
        vmem[0] = {16'd0, 16'd3};
        enable = 1'b1;
        step();
        step();
        step();
        for (int j = 0; j < 38; j++) begin
            load_complete = t_lc[j];
            step();
            chk($sformatf("tbl_pat_%0d", j), 32'(pattern_out), 32'(t_pat[j]));
            chk($sformatf("tbl_fs_%0d", j), 32'(frame_start), 32'(t_fs[j]));
            chk($sformatf("tbl_sd_%0d", j), 32'(swap_done), 32'(t_sd[j]));
            chk($sformatf("tbl_ab_%0d", j), 32'(active_buffer), 32'(t_ab[j]));
            if (j == 14) chk("swap_raddr", 32'(raddr), 32'h1000);
        end
        load_complete = 1'b0;

        // IDLE: load_complete swaps at once, output stays zero.
        enable = 1'b0;
        step();
        chk("idle_pattern", 32'(pattern_out), 32'h0);
        chk("idle_active", 32'(active_buffer), 32'h0);
        load_complete = 1'b1;
        step();
        load_complete = 1'b0;
        chk("idle_swap_active", 32'(active_buffer), 32'h1);
        chk("idle_swap_done", 32'(swap_done), 32'h1);
        chk("idle_swap_pattern", 32'(pattern_out), 32'h0);
        step();
        chk("idle_swap_done_clr", 32'(swap_done), 32'h0);
        chk("idle_hold_active", 32'(active_buffer), 32'h1);

        // Dropping enable on half 1 keeps active_buffer; reset clears it.
        enable = 1'b1;
        step();
        step();
        step();
        step();
        chk("h1_word0", 32'(pattern_out), 32'hAAAA);
        enable = 1'b0;
        step();
        chk("h1_drop_pattern", 32'(pattern_out), 32'h0);
        chk("h1_drop_active", 32'(active_buffer), 32'h1);
        chk("h1_drop_running", 32'(running), 32'h0);
        enable = 1'b1;
        step();
        step();
        step();
        step();
        chk("h1_re_word0", 32'(pattern_out), 32'hAAAA);
        chk("h1_re_fs", 32'(frame_start), 32'h1);
        reset = 1'b1;
        step();
        chk("midrst_pattern", 32'(pattern_out), 32'h0);
        chk("midrst_active", 32'(active_buffer), 32'h0);
        chk("midrst_running", 32'(running), 32'h0);
        chk("midrst_raddr", 32'(raddr), 32'h0);
        reset = 1'b0;
        enable = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
